alu_arbiter: RTL and testbench

- Shares one combinational ALUsimple instance between NREQ requesters.
- Each requester presents a valid/ready operation: rs1, rs2, and a 4-bit aluop.
- Requesters are arbitrated round-robin; the winner's operation is issued to the ALU from registers.
- The result and flag are captured and returned on a single response channel, tagged with the requester ID. One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU arbiter slice.
//   aluop_e      : ALUsimple opcode encoding (legal range 4'h1..4'hC)
//   arb_state_e  : arbiter FSM states
//   FLAG_ILLEGAL : bit index of the ILLEGAL flag in the 3-bit ALU flag
//   ALUOP_MAX    : highest legal opcode
//   is_legal_op  : opcode legality helper
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd1,
        SUB  = 4'd2,
        AND  = 4'd3,
        SLL  = 4'd4,
        SRL  = 4'd5,
        SRA  = 4'd6,
        SLT  = 4'd7,
        SLTU = 4'd8,
        SEXT = 4'd9,
        ZEXT = 4'd10,
        XOR  = 4'd11,
        NEG  = 4'd12
    } aluop_e;

    localparam int          FLAG_ILLEGAL = 2;
    localparam logic [3:0]  ALUOP_MAX    = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op != 4'h0) && (op <= ALUOP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant: picks the first asserted req at or
// after ptr, searching upward with wrap-around.
// Ports:
//   req          in  NREQ  request vector
//   ptr          in  IDW   highest-priority index this cycle
//   en           in  1     grant enable; no grant when low
//   grant_onehot out NREQ  one-hot grant (zero if none)
//   grant_idx    out IDW   index of the granted request (0 if none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx
);

    always_comb begin
        int   cand;
        logic found;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Modulo keeps the scan correct for non-power-of-two NREQ.
            cand = (int'(ptr) + i) % NREQ;
            if (en && !found && req[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALUsimple between NREQ valid/ready requesters.
// Round-robin arbitration, one operation in flight, registered issue to the
// ALU and a single tagged response channel.
// Optional: define ALU_ARB_PERF_EN to add saturating op_count/illegal_count.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   req_valid/req_ready  [NREQ]      per-requester handshake
//   req_rs1/req_rs2      [NREQ*W]    packed operands, slot i at [i*W +: W]
//   req_aluop            [NREQ*4]    packed opcodes, slot i at [i*4 +: 4]
//   alu_rs1/alu_rs2/alu_aluop        issue to ALUsimple (held between ops)
//   alu_rd/alu_flag                  result from ALUsimple
//   resp_valid/resp_ready            response handshake
//   resp_id/resp_rd/resp_flag        response payload
//   op_count/illegal_count           (ALU_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*WIDTH-1:0] req_rs1,
    input  logic [NREQ*WIDTH-1:0] req_rs2,
    input  logic [NREQ*4-1:0] req_aluop,
    output logic [WIDTH-1:0]  alu_rs1,
    output logic [WIDTH-1:0]  alu_rs2,
    output logic [3:0]        alu_aluop,
    input  logic [WIDTH-1:0]  alu_rd,
    input  logic [2:0]        alu_flag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [WIDTH-1:0]  resp_rd,
    output logic [2:0]        resp_flag
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       op_count,
    output logic [15:0]       illegal_count
`endif
);

    arb_state_e          state, state_next;
    logic [IDW-1:0]      rr_ptr;
    logic [NREQ-1:0]     grant_onehot;
    logic [IDW-1:0]      grant_idx;
    logic                accept;
    logic                resp_hs;

    logic [WIDTH-1:0]    op_rs1;
    logic [WIDTH-1:0]    op_rs2;
    logic [3:0]          op_aluop;
    logic [IDW-1:0]      op_id;

    // Gating with resetn keeps req_ready low while reset is held, even
    // though the state register already reads IDLE.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req          (req_valid),
        .ptr          (rr_ptr),
        .en           (resetn && (state == IDLE)),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign req_ready  = grant_onehot;
    assign accept     = |grant_onehot;
    assign resp_valid = (state == RESP);
    assign resp_hs    = resp_valid && resp_ready;

    // The ALU sees the issue registers directly, so it only toggles on accept.
    assign alu_rs1   = op_rs1;
    assign alu_rs2   = op_rs2;
    assign alu_aluop = op_aluop;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_rs1   <= '0;
            op_rs2   <= '0;
            op_aluop <= 4'h0;
            op_id    <= '0;
        end else if (accept) begin
            op_rs1   <= req_rs1[int'(grant_idx)*WIDTH +: WIDTH];
            op_rs2   <= req_rs2[int'(grant_idx)*WIDTH +: WIDTH];
            op_aluop <= req_aluop[int'(grant_idx)*4 +: 4];
            op_id    <= grant_idx;
        end
    end

    // An illegal result may be Z/X from the ALU; forcing it to zero keeps the
    // response channel clean.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_id   <= '0;
            resp_rd   <= '0;
            resp_flag <= 3'b000;
        end else if (state == EXEC) begin
            resp_id <= op_id;
            if (alu_flag[FLAG_ILLEGAL] || !is_legal_op(op_aluop)) begin
                resp_rd   <= '0;
                resp_flag <= 3'b100;
            end else begin
                resp_rd   <= alu_rd;
                resp_flag <= alu_flag;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_count      <= '0;
            illegal_count <= '0;
        end else if (resp_hs) begin
            if (op_count != '1) op_count <= op_count + 1'b1;
            if (resp_flag[FLAG_ILLEGAL] && (illegal_count != '1)) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a small stand-in ALU model. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_rs1;
    logic [NREQ*WIDTH-1:0] req_rs2;
    logic [NREQ*4-1:0]     req_aluop;
    logic [WIDTH-1:0]      alu_rs1;
    logic [WIDTH-1:0]      alu_rs2;
    logic [3:0]            alu_aluop;
    logic [WIDTH-1:0]      alu_rd;
    logic [2:0]            alu_flag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_rd;
    logic [2:0]            resp_flag;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]           op_count;
    logic [15:0]           illegal_count;
`endif

    int checks   = 0;
    int failures = 0;
    int id1_seen = 0;
    bit drop_window = 1'b0;

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_aluop  (req_aluop),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_aluop  (alu_aluop),
        .alu_rd     (alu_rd),
        .alu_flag   (alu_flag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_rd    (resp_rd),
        .resp_flag  (resp_flag)
`ifdef ALU_ARB_PERF_EN
        ,
        .op_count      (op_count),
        .illegal_count (illegal_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALUsimple: a few opcodes are modelled. Opcode 0 deliberately
    // returns garbage without raising ILLEGAL so the arbiter's own legality
    // check is exercised; 4'hD..4'hF raise ILLEGAL with a garbage result.
    always_comb begin
        logic [WIDTH-1:0] m_rd;
        m_rd     = '0;
        alu_flag = 3'b000;
        case (alu_aluop)
            4'd0:  m_rd = 16'hBEEF;
            4'd1:  m_rd = alu_rs1 + alu_rs2;
            4'd2:  m_rd = alu_rs1 - alu_rs2;
            4'd3:  m_rd = alu_rs1 & alu_rs2;
            4'd11: m_rd = alu_rs1 ^ alu_rs2;
            4'd12: m_rd = -alu_rs1;
            default: m_rd = '0;
        endcase
        if (alu_aluop >= 4'hD) begin
            m_rd     = 16'hDEAD;
            alu_flag = 3'b100;
        end else if (alu_aluop == 4'h0) begin
            alu_flag = 3'b001;
        end else begin
            alu_flag = {1'b0, m_rd[WIDTH-1], (m_rd == '0)};
        end
        alu_rd = m_rd;
    end

    always @(posedge clk) begin
        if (drop_window && resp_valid && resp_ready && (resp_id == IDW'(1))) id1_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [3:0] op);
        req_rs1[i*WIDTH +: WIDTH] = a;
        req_rs2[i*WIDTH +: WIDTH] = b;
        req_aluop[i*4 +: 4]       = op;
        req_valid[i]              = 1'b1;
    endtask

    // Waits (bounded) for resp_valid on falling edges; cycles = edges waited.
    task automatic wait_resp(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!resp_valid && cycles < 20);
        if (!resp_valid) check({tag, "_timeout"}, 32'(resp_valid), 'd1);
    endtask

    // Called on a falling edge with the arbiter idle: requester i must be
    // granted at once, issue for one cycle, and respond one edge later.
    task automatic do_op(input string tag, input int i, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [3:0] op);
        int cyc;
        set_req(i, a, b, op);
        #1 check({tag, "_grant"}, 32'(req_ready), 32'(1 << i));
        @(negedge clk);
        req_valid[i] = 1'b0;
        check({tag, "_exec_op"}, 32'(alu_aluop), 32'(op));
        check({tag, "_exec_nvalid"}, 32'(resp_valid), 'd0);
        wait_resp(tag, cyc);
        check({tag, "_lat"}, 32'(cyc), 'd1);
        check({tag, "_id"}, 32'(resp_id), 32'(i));
    endtask

    localparam logic [IDW-1:0] RR_ORDER [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        int cyc;
        int seen;
        resetn     = 1'b0;
        req_valid  = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_aluop  = '0;
        resp_ready = 1'b1;

        // Reset: outputs low even with every requester valid.
        req_valid = '1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 'd0);
        check("rst_resp_valid", 32'(resp_valid), 'd0);
        check("rst_resp_rd", 32'(resp_rd), 'd0);
        check("rst_alu_aluop", 32'(alu_aluop), 'd0);
        check("rst_alu_rs1", 32'(alu_rs1), 'd0);
        req_valid = '0;
        resetn    = 1'b1;
        @(negedge clk);

        // Single ADD from req0: 0x1234 + 0x0F0F = 0x2143. rr_ptr becomes 1.
        do_op("add", 0, 16'h1234, 16'h0F0F, 4'd1);
        check("add_rd", 32'(resp_rd), 'h2143);
        check("add_flag", 32'(resp_flag), 'b000);
        @(negedge clk);
        check("add_done", 32'(resp_valid), 'd0);
        check("add_hold_rs1", 32'(alu_rs1), 'h1234);

        // Round robin, all valid, SUB 10-3=7; rr_ptr starts at 1.
        for (int i = 0; i < NREQ; i++) set_req(i, 16'd10, 16'd3, 4'd2);
        for (int k = 0; k < 8; k++) begin
            wait_resp("rr", cyc);
            check($sformatf("rr%0d_gap", k), 32'(cyc), (k == 0) ? 'd2 : 'd3);
            check($sformatf("rr%0d_id", k), 32'(resp_id), 32'(RR_ORDER[k]));
            check($sformatf("rr%0d_rd", k), 32'(resp_rd), 'd7);
            if (k == 7) req_valid = '0;
        end
        @(negedge clk);

        // Backpressure: XOR 0xFF00^0x0FF0 = 0xF0F0 held; req0 waits meanwhile.
        resp_ready = 1'b0;
        do_op("bp", 1, 16'hFF00, 16'h0FF0, 4'd11);
        set_req(0, 16'd1, 16'd1, 4'd1);
        for (int j = 0; j < 5; j++) begin
            #1;
            check($sformatf("bp%0d_valid", j), 32'(resp_valid), 'd1);
            check($sformatf("bp%0d_rd", j), 32'(resp_rd), 'hF0F0);
            check($sformatf("bp%0d_flag", j), 32'(resp_flag), 'b010);
            check($sformatf("bp%0d_id", j), 32'(resp_id), 'd1);
            check($sformatf("bp%0d_ready", j), 32'(req_ready), 'd0);
            @(negedge clk);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_done", 32'(resp_valid), 'd0);

        // Illegal 4'hF from req2 (rr_ptr=2): ALU raises ILLEGAL.
        do_op("ill_f", 2, 16'd1834, 16'd3745, 4'hF);
        check("ill_f_rd", 32'(resp_rd), 'd0);
        check("ill_f_flag", 32'(resp_flag), 'b100);
        @(negedge clk);
`ifdef ALU_ARB_PERF_EN
        // 1 ADD + 8 SUB + 1 XOR + 1 illegal = 11 handshakes since reset.
        check("perf_op_11", op_count, 'd11);
        check("perf_ill_1", 32'(illegal_count), 'd1);
`endif
        // Opcode 0 from req3: ALU does not flag it, arbiter must.
        do_op("ill_0", 3, 16'h0001, 16'h0002, 4'h0);
        check("ill_0_rd", 32'(resp_rd), 'd0);
        check("ill_0_flag", 32'(resp_flag), 'b100);
        @(negedge clk);
`ifdef ALU_ARB_PERF_EN
        check("perf_op_12", op_count, 'd12);
        check("perf_ill_2", 32'(illegal_count), 'd2);
`endif
        // Highest legal opcode NEG from req0: -1 = 0xFFFF, flag negative.
        do_op("neg", 0, 16'd1, 16'd0, 4'hC);
        check("neg_rd", 32'(resp_rd), 'hFFFF);
        check("neg_flag", 32'(resp_flag), 'b010);
        @(negedge clk);

        // Mid-operation reset: req2 granted (rr_ptr would become 3), reset in EXEC.
        set_req(2, 16'd1, 16'd1, 4'd1);
        @(negedge clk);
        req_valid = '0;
        check("mrst_exec_rs1", 32'(alu_rs1), 'd1);
        #2 resetn = 1'b0;
        #1;
        check("mrst_resp_valid", 32'(resp_valid), 'd0);
        check("mrst_resp_rd", 32'(resp_rd), 'd0);
        check("mrst_alu_rs1", 32'(alu_rs1), 'd0);
        check("mrst_alu_aluop", 32'(alu_aluop), 'd0);
`ifdef ALU_ARB_PERF_EN
        check("mrst_op_count", op_count, 'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        seen   = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("mrst_no_resp", 32'(seen), 'd0);
        // req2 and req3 together: rr_ptr=0 after reset, so req2 wins.
        set_req(2, 16'd2, 16'd3, 4'd1);
        set_req(3, 16'd9, 16'd9, 4'd3);
        #1 check("mrst_grant", 32'(req_ready), 'b0100);
        @(negedge clk);
        req_valid = '0;
        wait_resp("mrst", cyc);
        check("mrst_id", 32'(resp_id), 'd2);
        check("mrst_rd", 32'(resp_rd), 'd5);
        @(negedge clk);

        // Requester drop: req1 pulses while req3 (rr_ptr=3) is in flight.
        drop_window = 1'b1;
        resp_ready  = 1'b0;
        set_req(3, 16'hFFFF, 16'h00FF, 4'd3);
        @(negedge clk);
        req_valid = '0;
        set_req(1, 16'd7, 16'd7, 4'd1);
        #1 check("drop_ready_exec", 32'(req_ready), 'd0);
        @(negedge clk);
        check("drop_ready_resp", 32'(req_ready), 'd0);
        req_valid = '0;
        check("drop_id", 32'(resp_id), 'd3);
        check("drop_rd", 32'(resp_rd), 'h00FF);
        resp_ready = 1'b1;
        @(negedge clk);
        // rr_ptr wrapped to 0: req0 is next; 5-5 = 0 gives the zero flag.
        do_op("after_drop", 0, 16'd5, 16'd5, 4'd2);
        check("after_drop_rd", 32'(resp_rd), 'd0);
        check("after_drop_flag", 32'(resp_flag), 'b001);
        @(negedge clk);
        drop_window = 1'b0;
        check("drop_id1_never", 32'(id1_seen), 'd0);
`ifdef ALU_ARB_PERF_EN
        // Since the mid-op reset: ADD, AND, SUB = 3 handshakes, none illegal.
        check("perf_op_end", op_count, 'd3);
        check("perf_ill_end", 32'(illegal_count), 'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
